food_spawner_grid: RTL
======================

Name: food_spawner_grid

Overview:
Parametrised successor to the fixed 8x8 food system. It places one food item on a 2^GRID_BITS x 2^GRID_BITS board using a free-running 16-bit LFSR, and rejects cells occupied by the snake body. After MAX_TRIES random hits it falls back to a deterministic linear scan. It also detects the head eating the food, keeps a saturating score, and flags a completely full board. It sits between the snake body/movement logic and the display/score logic.

Parameters:
GRID_BITS, 3, log2 of board side; N = 2^GRID_BITS; legal range 1..7
MAX_TRIES, 4, random placement attempts before linear scan; must be >=1
SEED, 16'hACE1, LFSR reset value; must be nonzero
SCORE_W, 8, score counter width

Ports:
clk_food  in  1  board clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
occupancy  in  N*N  body bitmap; bit index y*N+x; 1 = occupied
head_x  in  GRID_BITS  snake head column
head_y  in  GRID_BITS  snake head row
move_valid  in  1  one-cycle strobe: head_x/head_y hold a new head position
food_x  out  GRID_BITS  current food column
food_y  out  GRID_BITS  current food row
food_valid  out  1  food placed and displayable
food_eaten  out  1  one-cycle pulse when the head lands on the food
new_food_collision  out  1  one-cycle pulse per rejected random candidate
board_full  out  1  sticky flag: no free cell exists
score  out  SCORE_W  saturating count of foods eaten

Behaviour:
- Reset values: food_x=0, food_y=0, food_valid=0, food_eaten=0, new_food_collision=0, board_full=0, score=0, LFSR=SEED, tries=0, state=SPAWN.
- An assertion of reset at any time, including mid-SCAN or while in FULL, aborts the current operation immediately.
- LFSR: Fibonacci; it advances every cycle whenever reset is low.
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Candidate cell: cx = lfsr[GRID_BITS-1:0], cy = lfsr[2*GRID_BITS-1:GRID_BITS].
- States:
  - SPAWN: latch the candidate from the current LFSR value -> CHECK.
  - CHECK: test occupancy[cy*N+cx] on live input.
    - Free: food_x/food_y = candidate, food_valid=1, tries=0 -> ACTIVE.
    - Occupied: pulse new_food_collision for 1 cycle and increment tries. If tries+1 < MAX_TRIES -> SPAWN; else -> SCAN, with the scan pointer = candidate index + 1 mod N*N.
  - SCAN: test one cell per cycle at the scan pointer, then increment the pointer modulo N*N.
    - First free cell: place food there, food_valid=1 -> ACTIVE.
    - If N*N-1 consecutive cells are all occupied: board_full=1 -> FULL.
  - ACTIVE: if move_valid and head == food:
    - pulse food_eaten next cycle;
    - increment score, saturating at 2^SCORE_W-1;
    - set food_valid=0 in the same cycle food_eaten is high;
    - -> SPAWN.
    - When move_valid is high with a head mismatch, there is no effect.
  - FULL: terminal. food_valid=0; board_full holds until reset.
- move_valid outside ACTIVE is ignored (no eat, no score change).
- food_x/food_y hold their last placed value while food_valid=0.
- Latency:
  - empty-board spawn is 2 cycles (SPAWN, CHECK);
  - worst case is 2*MAX_TRIES + N*N - 1 cycles before food_valid or board_full.
- Occupancy may change during spawning; each check uses the value sampled in that cycle.
- Occupancy that appears later under a placed food is not rechecked.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Defaults, occupancy=0, reset pulse 10 ns -> food_valid=1 exactly 2 cycles after reset deasserts. food_x/food_y equal LFSR bits [2:0]/[5:3] sampled in SPAWN. new_food_collision never pulses.
2. Occupancy all ones except bit 22 -> MAX_TRIES=4 new_food_collision pulses, unless a random candidate hits cell (6,2) first. Food lands at x=6, y=2 within 2*4+63 cycles; board_full=0.
3. Occupancy all ones -> exactly 4 collision pulses, then board_full=1 after at most 71 cycles. food_valid stays 0, and board_full holds for 100 further cycles.
4. Food at (fx,fy); drive head=(fx,fy) with move_valid=1 for 1 cycle -> food_eaten high for exactly 1 cycle, score 0->1, and new food valid 2 cycles later. Head mismatch with move_valid -> no pulse.
5. SCORE_W=2, five eat events -> score goes 1,2,3,3,3, and food_eaten pulses all five times.
6. Occupancy all ones, assert reset during SCAN, then release with occupancy=0 -> all outputs return to their reset values, LFSR=16'hACE1, and food_valid=1 2 cycles after release.

Source files
------------

// File: rtl/food_spawner_grid.sv
// food_spawner_grid: LFSR food placement on a 2^G x 2^G board with
// linear-scan fallback, eat detection, saturating score, full flag.
module food_spawner_grid #(
  parameter int          GRID_BITS = 3,
  parameter int          MAX_TRIES = 4,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          SCORE_W   = 8
) (
  input  logic                             clk_food,
  input  logic                             reset,
  input  logic [(1<<(2*GRID_BITS))-1:0]    occupancy,
  input  logic [GRID_BITS-1:0]             head_x,
  input  logic [GRID_BITS-1:0]             head_y,
  input  logic                             move_valid,
  output logic [GRID_BITS-1:0]             food_x,
  output logic [GRID_BITS-1:0]             food_y,
  output logic                             food_valid,
  output logic                             food_eaten,
  output logic                             new_food_collision,
  output logic                             board_full,
  output logic [SCORE_W-1:0]               score
);
  localparam int IW = 2 * GRID_BITS;
  localparam int NN = 1 << IW;
  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    SPAWN, CHECK, SCAN, ACTIVE, FULL
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [15:0]   lfsr;
  logic [IW-1:0] cand;
  logic [IW-1:0] ptr;
  logic [IW-1:0] scan_cnt;
  logic [IW-1:0] food;
  logic [TW-1:0] tries;
  logic          last_try;
  logic          scan_last;
  logic          eat;
  logic          do_latch;
  logic          do_place_c;
  logic          do_coll;
  logic          do_scan_go;
  logic          do_place_s;
  logic          do_step;
  logic          do_full;
  logic          do_eat;

  // cell index y*N+x is just {y,x}, so the candidate is lfsr[IW-1:0]
  assign last_try  = (int'(tries) + 1 >= MAX_TRIES);
  assign scan_last = (scan_cnt == IW'(NN - 2));
  assign eat       = move_valid
                   && (head_x == food[GRID_BITS-1:0])
                   && (head_y == food[IW-1:GRID_BITS]);
  assign food_x    = food[GRID_BITS-1:0];
  assign food_y    = food[IW-1:GRID_BITS];

  // free-running Fibonacci LFSR
  always_ff @(posedge clk_food or posedge reset) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[14:0],
                        lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // state register
  always_ff @(posedge clk_food or posedge reset) begin
    if (reset) state <= SPAWN;
    else       state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      SPAWN:  state_nx = CHECK;
      CHECK: begin
        if (!occupancy[cand]) state_nx = ACTIVE;
        else if (last_try)    state_nx = SCAN;
        else                  state_nx = SPAWN;
      end
      SCAN: begin
        if (!occupancy[ptr]) state_nx = ACTIVE;
        else if (scan_last)  state_nx = FULL;
      end
      ACTIVE: if (eat) state_nx = SPAWN;
      FULL:   state_nx = FULL;
      default: state_nx = SPAWN;
    endcase
  end

  // per-state datapath strobes
  always_comb begin
    do_latch   = 1'b0;
    do_place_c = 1'b0;
    do_coll    = 1'b0;
    do_scan_go = 1'b0;
    do_place_s = 1'b0;
    do_step    = 1'b0;
    do_full    = 1'b0;
    do_eat     = 1'b0;
    unique case (state)
      SPAWN: do_latch = 1'b1;
      CHECK: begin
        if (!occupancy[cand]) begin
          do_place_c = 1'b1;
        end else begin
          do_coll    = 1'b1;
          do_scan_go = last_try;
        end
      end
      SCAN: begin
        if (!occupancy[ptr]) do_place_s = 1'b1;
        else if (scan_last)  do_full    = 1'b1;
        else                 do_step    = 1'b1;
      end
      ACTIVE: do_eat = eat;
      default: ;
    endcase
  end

  // registered datapath and outputs
  always_ff @(posedge clk_food or posedge reset) begin
    if (reset) begin
      cand               <= '0;
      ptr                <= '0;
      scan_cnt           <= '0;
      tries              <= '0;
      food               <= '0;
      food_valid         <= 1'b0;
      food_eaten         <= 1'b0;
      new_food_collision <= 1'b0;
      board_full         <= 1'b0;
      score              <= '0;
    end else begin
      food_eaten         <= do_eat;
      new_food_collision <= do_coll;
      if (do_latch) cand <= lfsr[IW-1:0];
      if (do_coll) tries <= do_scan_go ? '0 : tries + 1'b1;
      if (do_scan_go) begin
        ptr      <= cand + 1'b1;
        scan_cnt <= '0;
      end
      if (do_step) begin
        ptr      <= ptr + 1'b1;
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (do_place_c) begin
        food       <= cand;
        food_valid <= 1'b1;
        tries      <= '0;
      end
      if (do_place_s) begin
        food       <= ptr;
        food_valid <= 1'b1;
      end
      if (do_full) begin
        board_full <= 1'b1;
        food_valid <= 1'b0;
      end
      if (do_eat) begin
        food_valid <= 1'b0;
        if (score != '1) score <= score + 1'b1;
      end
    end
  end
endmodule
